// File: rtl/inst_fetch_pkg.sv
// Shared widths, FSM state type and branch-offset helper for the fetch stage.
package inst_fetch_pkg;

  localparam int unsigned dwidth_inst = 32;
  localparam int unsigned imem_depth  = 256;
  localparam int unsigned pc_w        = $clog2(imem_depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // B-type imm[12:2] is the word offset; sign-extend it to 32 bits.
  function automatic logic [31:0] bimm_word_off(input logic [10:0] imm_12_2);
    return {{21{imm_12_2[10]}}, imm_12_2};
  endfunction

endpackage

// File: rtl/imem_sdp.sv
// Simple dual-port instruction RAM: one write port, one synchronous read port.
module imem_sdp #(
  parameter int unsigned depth = 256,
  parameter int unsigned width = 32,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             ren,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: host-loaded IMEM, PC sequencing, stall, bne redirect, done.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DWIDTH_INST = dwidth_inst,
  parameter int unsigned IMEM_DEPTH  = imem_depth,
  parameter int unsigned PC_W        = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_wen,
  input  logic [PC_W-1:0]        imem_waddr,
  input  logic [DWIDTH_INST-1:0] imem_wdata,
  input  logic [PC_W:0]          prog_len,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [11:0]            branch_immediate,
  output logic [DWIDTH_INST-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_W-1:0]        instr_pc,
  output logic                   busy,
  output logic                   done
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ipc_q, ipc_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [PC_W:0]    len_q, len_d;

  logic             hold;
  logic             redirect;
  logic [PC_W-1:0]  target;
  logic [PC_W:0]    pc_next;
  logic             mem_wen;
  logic [DWIDTH_INST-1:0] rdata;
  logic             imm_lsb_unused;

  assign imm_lsb_unused = branch_immediate[0];

  // RAM output register only advances when the stage advances, so a held
  // instruction stays on rdata while pc already points one word ahead.
  imem_sdp #(
    .depth (IMEM_DEPTH),
    .width (DWIDTH_INST),
    .aw    (PC_W)
  ) u_imem (
    .clk   (clk),
    .wen   (mem_wen),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .ren   (~hold),
    .raddr (pc_q),
    .rdata (rdata)
  );

  always_comb begin
    hold     = stall & valid_q;
    redirect = branch_taken & valid_q & ~stall;
    target   = ipc_q + PC_W'(bimm_word_off(branch_immediate[11:1]));
    pc_next  = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
    mem_wen  = imem_wen & ((state_q == IDLE) | (state_q == DONE));

    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    done_d  = done_q;
    len_d   = len_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d   = prog_len;
          pc_d    = '0;
          valid_d = 1'b0;
          if (prog_len == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            done_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else if (!hold) begin
          if ({1'b0, pc_q} < len_q) begin
            valid_d = 1'b1;
            ipc_d   = pc_q;
            pc_d    = pc_next[PC_W-1:0];
            if (pc_next >= len_q) state_d = DRAIN;
          end else begin
            valid_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!hold) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

  assign instr       = valid_q ? rdata : '0;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;
  assign done        = done_q;
  assign busy        = (state_q == RUN) | (state_q == DRAIN);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: straight line, stall, branches, edge cases, reset.
module tb_inst_fetch;

  localparam int unsigned PC_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_wen;
  logic [PC_W-1:0]   imem_waddr;
  logic [31:0]       imem_wdata;
  logic [PC_W:0]     prog_len;
  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [11:0]       branch_immediate;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [PC_W-1:0]   instr_pc;
  logic              busy;
  logic              done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  inst_fetch #(
    .DWIDTH_INST (32),
    .IMEM_DEPTH  (256)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .imem_wen         (imem_wen),
    .imem_waddr       (imem_waddr),
    .imem_wdata       (imem_wdata),
    .prog_len         (prog_len),
    .start            (start),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_immediate (branch_immediate),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_pc         (instr_pc),
    .busy             (busy),
    .done             (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_prog(input logic [PC_W:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst = 1'b1; imem_wen = 1'b0; imem_waddr = '0; imem_wdata = '0;
    prog_len = '0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_immediate = '0;

    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc",    instr_pc, 0);
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      imem_wen = 1'b1; imem_waddr = PC_W'(i); imem_wdata = 32'hA0 + i;
      tick();
    end
    imem_wen = 1'b0;

    // straight line, 4 words
    start_prog(4);
    chk("sl_busy",  busy, 1);
    chk("sl_valid0", instr_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sl_valid", instr_valid, 1);
      chk("sl_pc",    instr_pc, i);
      chk("sl_instr", instr, 32'hA0 + i);
      tick();
    end
    chk("sl_done",   done, 1);
    chk("sl_valid_end", instr_valid, 0);
    chk("sl_busy_end",  busy, 0);

    // stall for 3 cycles on word 1
    start_prog(4);
    chk("st_done_clr", done, 0);
    tick(); tick();
    chk("st_pc1", instr_pc, 1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_hold_pc",    instr_pc, 1);
      chk("st_hold_instr", instr, 32'hA1);
      chk("st_hold_valid", instr_valid, 1);
    end
    stall = 1'b0;
    tick(); chk("st_pc2", instr_pc, 2); chk("st_instr2", instr, 32'hA2);
    tick(); chk("st_pc3", instr_pc, 3); chk("st_instr3", instr, 32'hA3);
    tick(); chk("st_done", done, 1); chk("st_valid_end", instr_valid, 0);

    // backward branch at pc 5, offset -5 words
    start_prog(8);
    for (int k = 0; k < 6; k++) tick();
    chk("bb_pc5", instr_pc, 5);
    chk("bb_instr5", instr, 32'hA5);
    branch_taken = 1'b1; branch_immediate = 12'hFF6;
    tick();
    branch_taken = 1'b0;
    chk("bb_bubble", instr_valid, 0);
    tick();
    chk("bb_valid", instr_valid, 1);
    chk("bb_pc0", instr_pc, 0);
    chk("bb_instr0", instr, 32'hA0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("bb_seq_pc", instr_pc, k);
    end
    tick();
    chk("bb_done", done, 1);

    // branch held off by stall for 2 cycles, +3 words from pc 2
    start_prog(8);
    tick(); tick(); tick();
    chk("bs_pc2", instr_pc, 2);
    branch_taken = 1'b1; branch_immediate = 12'h006; stall = 1'b1;
    tick(); chk("bs_hold1", instr_pc, 2); chk("bs_hold1_v", instr_valid, 1);
    tick(); chk("bs_hold2", instr_pc, 2); chk("bs_hold2_v", instr_valid, 1);
    stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    chk("bs_bubble", instr_valid, 0);
    tick(); chk("bs_pc5", instr_pc, 5); chk("bs_instr5", instr, 32'hA5);
    tick(); chk("bs_pc6", instr_pc, 6); chk("bs_valid6", instr_valid, 1);
    tick(); chk("bs_pc7", instr_pc, 7);
    tick(); chk("bs_done", done, 1);

    // forward branch beyond prog_len
    start_prog(4);
    tick(); tick();
    chk("oor_pc1", instr_pc, 1);
    branch_taken = 1'b1; branch_immediate = 12'h00A;
    tick();
    branch_taken = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      chk("oor_valid", instr_valid, 0);
      if (done) seen = 1'b1;
      else tick();
    end
    chk("oor_done", done, 1);

    // empty program
    start_prog(0);
    chk("zero_done",  done, 1);
    chk("zero_valid", instr_valid, 0);
    chk("zero_busy",  busy, 0);
    tick();
    chk("zero_valid2", instr_valid, 0);

    // host write while running is dropped
    start_prog(4);
    imem_wen = 1'b1; imem_waddr = 8'd2; imem_wdata = 32'hDEADBEEF;
    tick();
    imem_wen = 1'b0;
    tick(); tick();
    chk("wr_pc2",    instr_pc, 2);
    chk("wr_instr2", instr, 32'hA2);
    tick(); tick();
    chk("wr_done", done, 1);

    // asynchronous reset mid-run, then restart
    start_prog(8);
    tick(); tick(); tick();
    chk("mr_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", instr_valid, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_done",  done, 0);
    chk("mr_instr", instr, 0);
    chk("mr_pc",    instr_pc, 0);
    tick();
    rst = 1'b0;
    start_prog(4);
    for (int k = 0; k < 4; k++) tick();
    chk("mr_pc3",    instr_pc, 3);
    chk("mr_instr3", instr, 32'hA3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
